// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller / interval timer: register
// byte offsets, control and cause bit positions, default base address.
package irq_pkg;

  localparam logic [31:0] IRQ_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [4:0] TH_OFS     = 5'h00;
  localparam logic [4:0] TL_OFS     = 5'h04;
  localparam logic [4:0] TCON_OFS   = 5'h08;
  localparam logic [4:0] IMASK_OFS  = 5'h0C;
  localparam logic [4:0] IPEND_OFS  = 5'h10;
  localparam logic [4:0] ICAUSE_OFS = 5'h14;
  localparam logic [31:0] WIN_BYTES = 32'h18;

  localparam int TCON_TEN     = 0;
  localparam int ICAUSE_VALID = 31;
  localparam int CAUSE_W      = 5;

  // Returns {valid, index} of the lowest set bit; lower index has priority.
  function automatic logic [CAUSE_W:0] lowest_set(input logic [31:0] v);
    logic [CAUSE_W:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = {1'b1, CAUSE_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous request line followed by a
// rising-edge detector producing a single-cycle pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      // metastability stage -> synchronized stage -> history for edge detect
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt controller with 32-bit reload timer.
// Build option IRQ_EXT_EN: adds the external request lines and their pending/mask bits.
module irq_timer_ctrl
  import irq_pkg::*;
#(
  parameter int          N_EXT     = 4,
  parameter logic [31:0] BASE_ADDR = IRQ_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             MemRd,
  input  logic             MemWr,
  output logic [31:0]      rdata,
  output logic             hit,
  input  logic [N_EXT-1:0] ext_irq,
  output logic             IRQ
);

`ifdef IRQ_EXT_EN
  localparam int PW = N_EXT + 1;
`else
  localparam int PW = 1;
`endif

  logic [31:0]      ofs;
  logic [4:0]       sel;
  logic             wr;
  logic [31:0]      th;
  logic [31:0]      tl;
  logic             ten;
  logic [PW-1:0]    imask;
  logic [PW-1:0]    ipend;
  logic [PW-1:0]    evt;
  logic [PW-1:0]    w1c;
  logic [PW-1:0]    act;
  logic             ovf;
  logic             wr_tl;
  logic [CAUSE_W:0] cause;

  // Unsigned wrap makes addresses below the base fail the window check too.
  assign ofs   = addr - BASE_ADDR;
  assign hit   = (ofs < WIN_BYTES);
  assign sel   = {ofs[4:2], 2'b00};
  assign wr    = MemWr & hit;
  assign wr_tl = wr && (sel == TL_OFS);

  // A bus write to TL suppresses both the increment and the overflow flag.
  assign ovf = ten & ~wr_tl & (tl == 32'hFFFF_FFFF);

`ifdef IRQ_EXT_EN
  logic [N_EXT-1:0] ext_pulse;

  for (genvar i = 0; i < N_EXT; i++) begin : g_ext
    irq_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ext_irq[i]),
      .pulse    (ext_pulse[i])
    );
  end

  assign evt = {ext_pulse, ovf};
`else
  logic [N_EXT-1:0] ext_unused;
  assign ext_unused = ext_irq;
  assign evt        = ovf;
`endif

  assign w1c   = (wr && (sel == IPEND_OFS)) ? wdata[PW-1:0] : '0;
  assign act   = ipend & imask;
  assign IRQ   = |act;
  assign cause = lowest_set(32'(act));

  always_ff @(posedge clk) begin
    if (reset) begin
      th    <= '0;
      tl    <= '0;
      ten   <= 1'b0;
      imask <= '0;
      ipend <= '0;
    end else begin
      if (wr && (sel == TH_OFS))    th    <= wdata;
      if (wr && (sel == TCON_OFS))  ten   <= wdata[TCON_TEN];
      if (wr && (sel == IMASK_OFS)) imask <= wdata[PW-1:0];

      if (wr_tl)      tl <= wdata;
      else if (ovf)   tl <= th;
      else if (ten)   tl <= tl + 32'd1;

      // New events are ORed in after the clear so a coincident event survives.
      ipend <= (ipend & ~w1c) | evt;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && MemRd) begin
      case (sel)
        TH_OFS:     rdata = th;
        TL_OFS:     rdata = tl;
        TCON_OFS:   rdata[TCON_TEN] = ten;
        IMASK_OFS:  rdata = 32'(imask);
        IPEND_OFS:  rdata = 32'(ipend);
        ICAUSE_OFS: begin
          rdata[ICAUSE_VALID]  = cause[CAUSE_W];
          rdata[CAUSE_W-1:0]   = cause[CAUSE_W-1:0];
        end
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed self-checking bench for irq_timer_ctrl; follows the IRQ_EXT_EN build option.
module tb_irq_timer_ctrl;

  localparam logic [31:0] B = 32'h4000_0000;
`ifdef IRQ_EXT_EN
  localparam logic [31:0] MASK_ALL = 32'h0000_001F;
`else
  localparam logic [31:0] MASK_ALL = 32'h0000_0001;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  ext_irq;
  logic        IRQ;
  logic [31:0] d;

  int n_chk  = 0;
  int n_fail = 0;

  irq_timer_ctrl #(.N_EXT(4), .BASE_ADDR(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .MemRd   (MemRd),
    .MemWr   (MemWr),
    .rdata   (rdata),
    .hit     (hit),
    .ext_irq (ext_irq),
    .IRQ     (IRQ)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] ofs, input logic [31:0] v);
    addr  = B + 32'(ofs);
    wdata = v;
    MemWr = 1'b1;
    tick();
    MemWr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] ofs, input logic [31:0] exp);
    addr  = B + 32'(ofs);
    MemRd = 1'b1;
    #1;
    chk(tag, rdata, exp);
    MemRd = 1'b0;
    #1;
  endtask

  // Leaves TL at FFFF_FFFF with TEN=1 for exactly one edge, then stops the timer.
  task automatic fire_timer();
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h08, 32'h1);
    wr(5'h08, 32'h0);
  endtask

  task automatic pulse_ext(input int line);
    ext_irq[line] = 1'b1;
    tick();
    tick();
    ext_irq[line] = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; MemRd = 1'b0; MemWr = 1'b0; ext_irq = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    for (int i = 0; i < 6; i++) rd_chk($sformatf("rst_reg%0d", i), 5'(i * 4), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    addr = B;            #1; chk("hit_base", 32'(hit), 32'h1);
    addr = B + 32'h14;   #1; chk("hit_cause", 32'(hit), 32'h1);
    addr = B + 32'h18;   #1; chk("hit_past", 32'(hit), 32'h0);
    addr = B - 32'h4;    #1; chk("hit_below", 32'(hit), 32'h0);

    // timer overflow and reload
    wr(5'h00, 32'hFFFF_FFFC);
    wr(5'h04, 32'hFFFF_FFFE);
    wr(5'h0C, 32'h1);
    wr(5'h08, 32'h1);
    tick();
    tick();
    rd_chk("ovf_ipend", 5'h10, 32'h1);
    chk("ovf_irq", 32'(IRQ), 32'h1);
    rd_chk("ovf_tl", 5'h04, 32'hFFFF_FFFC);
    rd_chk("ovf_cause", 5'h14, 32'h8000_0000);
    wr(5'h10, 32'h1);
    chk("w1c_irq", 32'(IRQ), 32'h0);
    rd_chk("w1c_tl", 5'h04, 32'hFFFF_FFFD);
    tick();
    tick();
    chk("period_early", 32'(IRQ), 32'h0);
    tick();
    chk("period_irq", 32'(IRQ), 32'h1);
    rd_chk("period_tl", 5'h04, 32'hFFFF_FFFC);

    // W1C coinciding with overflow: the set wins
    wr(5'h10, 32'h1);
    rd_chk("clr_ipend", 5'h10, 32'h0);
    tick();
    tick();
    wr(5'h10, 32'h1);
    rd_chk("coll_w1c_ipend", 5'h10, 32'h1);

    // TL write coinciding with overflow: write wins, no flag
    wr(5'h10, 32'h1);
    tick();
    tick();
    wr(5'h04, 32'h10);
    rd_chk("coll_tl", 5'h04, 32'h10);
    rd_chk("coll_tl_ipend", 5'h10, 32'h0);
    chk("coll_tl_irq", 32'(IRQ), 32'h0);

    // TCON write takes effect on the following count
    wr(5'h08, 32'h0);
    tick();
    tick();
    rd_chk("hold_tl", 5'h04, 32'h11);
    wr(5'h08, 32'hFFFF_FFFE);
    rd_chk("tcon_bits", 5'h08, 32'h0);
    tick();
    rd_chk("hold_tl2", 5'h04, 32'h11);
    addr = B + 32'h4; MemRd = 1'b0; #1;
    chk("rdata_idle", rdata, 32'h0);
    wr(5'h0C, 32'hFFFF_FFFF);
    rd_chk("imask_bits", 5'h0C, MASK_ALL);

`ifdef IRQ_EXT_EN
    // external line 2, synchronizer latency
    wr(5'h0C, 32'h08);
    ext_irq[2] = 1'b1;
    tick();
    tick();
    ext_irq[2] = 1'b0;
    rd_chk("ext_lat", 5'h10, 32'h0);
    tick();
    rd_chk("ext_ipend", 5'h10, 32'h08);
    rd_chk("ext_cause", 5'h14, 32'h8000_0003);
    chk("ext_irq", 32'(IRQ), 32'h1);
    ext_irq[2] = 1'b1;
    repeat (3) tick();
    wr(5'h10, 32'h08);
    repeat (3) tick();
    rd_chk("ext_level", 5'h10, 32'h0);
    chk("ext_level_irq", 32'(IRQ), 32'h0);
    ext_irq[2] = 1'b0;

    // priority and masking
    pulse_ext(0);
    fire_timer();
    wr(5'h0C, 32'h03);
    rd_chk("prio_timer", 5'h14, 32'h8000_0000);
    wr(5'h0C, 32'h02);
    rd_chk("prio_ext0", 5'h14, 32'h8000_0001);
    wr(5'h0C, 32'h00);
    rd_chk("mask_cause", 5'h14, 32'h0);
    chk("mask_irq", 32'(IRQ), 32'h0);
    rd_chk("mask_ipend", 5'h10, 32'h03);

    wr(5'h10, 32'h03);
    pulse_ext(1);
    fire_timer();
    wr(5'h0C, 32'h1F);
    rd_chk("pre_rst_ipend", 5'h10, 32'h05);
    chk("pre_rst_irq", 32'(IRQ), 32'h1);
`else
    ext_irq = 4'hF;
    repeat (4) tick();
    ext_irq = 4'h0;
    rd_chk("ext_ignored", 5'h10, 32'h0);
    fire_timer();
    wr(5'h0C, 32'h0);
    rd_chk("mask_cause", 5'h14, 32'h0);
    chk("mask_irq", 32'(IRQ), 32'h0);
    rd_chk("mask_ipend", 5'h10, 32'h1);
    wr(5'h0C, 32'h1);
    rd_chk("unmask_cause", 5'h14, 32'h8000_0000);
    chk("pre_rst_irq", 32'(IRQ), 32'h1);
`endif

    // reset mid-operation with an edge in the synchronizer
    wr(5'h08, 32'h1);
    ext_irq[0] = 1'b1;
    tick();
    reset = 1'b1;
    ext_irq[0] = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) rd_chk($sformatf("mid_rst_reg%0d", i), 5'(i * 4), 32'h0);
    chk("mid_rst_irq", 32'(IRQ), 32'h0);
    repeat (4) tick();
    rd_chk("mid_rst_drop", 5'h10, 32'h0);
    rd_chk("mid_rst_tl", 5'h04, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_timer_ctrl.md
# irq_timer_ctrl

Memory-mapped interrupt controller and interval timer for the single-cycle MIPS core. It sequences the core's `IRQ` input: a 32-bit reload timer plus external request lines set bits in a pending register, and the lowest-numbered masked pending source is reported as the cause. The core's control unit gates `IRQ` with the kernel bit to take the trap. The block sits on the data-memory bus beside data RAM, decoded from `BASE_ADDR`.

## Interface
- `N_EXT`, 4: number of external interrupt lines, legal range 1..31.
- `BASE_ADDR`, 32'h4000_0000: base of the 6-word register window.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `addr` in 32: data bus byte address. Bits [1:0] are ignored.
- `wdata` in 32: store data.
- `MemRd` in 1: load strobe.
- `MemWr` in 1: store strobe, takes effect at the clock edge.
- `rdata` out 32: load data, combinational.
- `hit` out 1: `addr` falls in [BASE_ADDR, BASE_ADDR+0x17]. Combinational; the bus mux selects `rdata` on it.
- `ext_irq` in N_EXT: asynchronous, rising-edge-sensitive requests.
- `IRQ` out 1: interrupt request to the control unit.

## Operation
- Register map (offsets):
  - 0x00 TH: reload value, rw.
  - 0x04 TL: counter, rw.
  - 0x08 TCON: rw. Bit0 TEN (timer run). Other bits read 0.
  - 0x0C IMASK: rw, bits [N_EXT:0]. Bit0 is the timer; bits [N_EXT:1] are ext lines 0..N_EXT-1.
  - 0x10 IPEND: read. Writing 1 to a bit clears it (W1C); writing 0 leaves it.
  - 0x14 ICAUSE: ro. Bit31 = valid. Bits [4:0] = lowest index i with IPEND[i]&IMASK[i].
- Unimplemented bits read 0. Writes outside `hit` are ignored.
- `rdata` = selected register when `hit`&`MemRd`, else 0.
- Timer, each edge with TEN=1:
  - TL==32'hFFFF_FFFF: TL<=TH, and IPEND[0] is set.
  - Otherwise TL<=TL+1.
  - TEN=0 holds TL.
- External line: 2-flop synchronizer, then rising-edge detect (sync2 & ~prev). The detected edge sets IPEND[i+1]. Level-high does not re-trigger.
- `IRQ` = |(IPEND & IMASK).
  - Level output. It stays high until software clears the pending bit or masks it.
  - No internal acknowledge. The ISR must W1C IPEND before `eret`/jr.
- Priority: lower index wins in ICAUSE. The timer beats all external lines.
- Simultaneous events:
  - Set beats W1C clear in the same cycle, so no event is lost.
  - A software write to TL beats timer increment/reload; the overflow is not flagged that cycle.
  - A software write to TCON takes effect on the following cycle's count.
- Reset mid-operation: all state returns to reset values at that edge. Edges already in the synchronizer are dropped.

## Timing
- Reset values:
  - TH=0, TL=0, TCON=0, IMASK=0, IPEND=0.
  - Synchronizer and prev flops = 0.
  - `IRQ`=0. `rdata`=0. `hit` follows `addr`.
- Register write: visible on `rdata` the cycle after the `MemWr` edge.
- Timer overflow:
  - At the edge where TL reaches FFFF_FFFF and wraps, IPEND[0] becomes 1.
  - `IRQ` rises immediately after that edge if masked in.
- External line rising before edge k: sync1@k, sync2@k+1, IPEND set @k+2. `IRQ` goes high after edge k+2 (3rd edge).
- Minimum pulse width on `ext_irq`: 2 clk periods. Narrower pulses may be missed.
- Reload period with TH=T: 2^32−T cycles between overflows.

## Configuration
- `IRQ_EXT_EN`, defined: the external lines, synchronizers and IPEND/IMASK bits [N_EXT:1] are built.
- `IRQ_EXT_EN`, undefined:
  - `ext_irq` is still present on the port list but ignored.
  - IMASK/IPEND are 1 bit (timer only); upper bits read 0.
  - ICAUSE is valid only for index 0.

## Structure
- Shared package `irq_pkg`:
  - Register offsets (TH_OFS..ICAUSE_OFS).
  - TCON_TEN bit position.
  - ICAUSE_VALID bit position.
  - Default BASE_ADDR.
  - Cause index width (5).
- Sub-module `irq_sync_edge`: per-line 2-flop synchronizer plus rising-edge pulse. It is instantiated N_EXT times in a generate loop under `IRQ_EXT_EN`.

## Test plan
- Reset, then read all 6 offsets:
  - All read 0; `IRQ`=0.
  - `hit`=1 for 0x4000_0000..0x4000_0014; `hit`=0 for 0x4000_0018.
- Timer: TH=FFFF_FFFC, TL=FFFF_FFFE, IMASK=1, TEN=1:
  - IPEND[0] and `IRQ` are 1 after the 2nd edge, and TL=FFFF_FFFC.
  - W1C IPEND=1 drops `IRQ` next cycle; the next overflow follows 4 cycles later.
- Ext line 2 pulse 2 cycles, IMASK=0x08:
  - IPEND=0x08 at the 3rd edge; ICAUSE=0x8000_0003; `IRQ`=1.
  - Holding the line high does not re-set after W1C.
- Priority and mask: timer and ext0 pending, IMASK=0x03:
  - ICAUSE=0x8000_0000.
  - With IMASK=0x02, ICAUSE=0x8000_0001.
  - With IMASK=0, ICAUSE=0 and `IRQ`=0 while IPEND stays 0x03.
- Collision: W1C IPEND[0] in the same cycle as a timer overflow sets it → IPEND[0] remains 1.
- Collision: a TL write of 0x10 on the overflow cycle → TL=0x10 and no flag.
- Reset asserted mid-count with IPEND=0x05: next cycle all registers are 0 and `IRQ`=0. A rising edge in flight when reset is asserted is not captured.
